input_conditioner: RTL and testbench
====================================

# input_conditioner

Synchronises and debounces the DE0 slide switches and push-buttons before they reach the game logic. It produces clean switch levels for the column answer comparison, and clean button levels and one-cycle press/release strobes for the game state machine reset path. It sits directly upstream of the top-level game wiring and replaces raw `SW`/`~BUTTON` taps with conditioned signals. All bits are conditioned independently with identical logic.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised cycles a new level must persist before it is accepted (10 ms at 50 MHz). Legal range is ≥1.
- `CNT_W`, default 19: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clock`  in  1: 50 MHz system clock. All state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sw_raw`  in  8: raw slide switches, active-high, asynchronous to `clock`.
- `button_raw`  in  3: raw push-buttons, active-low (0 = pressed), asynchronous.
- `sw_stable`  out  8: debounced switch levels.
- `sw_changed`  out  1: one-cycle strobe; at least one `sw_stable` bit updated.
- `button_level`  out  3: debounced button state, active-high (1 = pressed).
- `button_press`  out  3: one-cycle strobe per bit on a debounced 0→1 of `button_level`.
- `button_release`  out  3: one-cycle strobe per bit on a debounced 1→0 of `button_level`.

## Operation
- **Synchroniser:** a 2-flop synchroniser per input bit. Buttons are inverted before the synchroniser, so everything downstream is active-high.
- **Per-bit FSM state:**
  - STABLE: synchronised value equals the accepted value. Counter is held at 0.
  - PENDING: synchronised value differs from the accepted value. Counter increments each cycle.
- **Transitions:**
  - STABLE→PENDING on the first edge with a mismatch. Counter goes to 1, or the value is accepted immediately if DEBOUNCE_CYCLES = 1.
  - PENDING→STABLE with no update if the mismatch disappears. Counter clears to 0 on that edge.
  - PENDING→STABLE with an update on the edge where the mismatch persists and counter = DEBOUNCE_CYCLES−1. The accepted value flips and the counter clears.
- **Strobes:**
  - Registered on the same edge as the accepted-value update, so the strobe and the new level are visible in the same cycle.
  - Each strobe is high for exactly one cycle.
  - `sw_changed` is the OR of all switch-bit updates on that edge.
- **Simultaneous events:** bits are fully independent. Several bits may update on one edge. One `sw_changed` pulse covers all of them. `button_press` and `button_release` may be asserted on different bits in the same cycle.
- **Counter width:** the counter never exceeds DEBOUNCE_CYCLES−1, so it cannot wrap.
- **Reset values (asynchronous, immediate):**
  - Synchroniser flops: switches 0, buttons 0 (released, after inversion).
  - All counters 0, all FSMs STABLE.
  - `sw_stable` 0, `button_level` 0, `sw_changed` 0, `button_press` 0, `button_release` 0.
- **Reset mid-debounce:** pending transitions are discarded. After reset release, an input already at a non-reset level is re-debounced from scratch and produces normal strobes.

## Timing
- Acceptance latency: a raw change sampled first at edge 1 and held updates its output at edge 2+DEBOUNCE_CYCLES.
- Acceptance threshold:
  - A raw level held for DEBOUNCE_CYCLES consecutive sampling edges is accepted.
  - A level held for DEBOUNCE_CYCLES−1 edges or fewer is rejected with no output change and no strobe.
- Minimum spacing between two strobes on the same bit is DEBOUNCE_CYCLES cycles.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=3.
- **Reset values:** assert `reset_n`=0 mid-clock with `sw_raw`=8'hFF → all outputs 0 immediately. Release reset and hold `sw_raw` → `sw_stable`=8'hFF at the 6th edge after release, with `sw_changed`=1 for that one cycle.
- **Clean press:** `button_raw[2]` driven 1→0 before edge 1 and held → `button_level[2]`=1 and `button_press[2]`=1 at edge 6. `button_press[2]` is 0 at edge 7. No `button_release` pulse.
- **Bounce rejection:**
  - `sw_raw[0]` pulsed high for 3 edges, then low → `sw_stable` stays 0 and `sw_changed` never pulses.
  - Then 1 for 2 edges, 0 for 1, 1 held → accepted at edge 6 counted from the final rise.
- **Simultaneous bits:** `sw_raw` changes 8'h00→8'hA5 in one cycle → `sw_stable`=8'hA5 at edge 6 with a single `sw_changed` pulse.
- **Press + release mix:** button0 released while button1 pressed in the same cycle → at edge 6, `button_release`=3'b001 and `button_press`=3'b010 together, each for one cycle.
- **Reset mid-debounce:** start a `sw_raw[3]` change, then assert `reset_n` at edge 4 for 1 cycle while the input stays high → no update before reset. Output updates at edge 6 counted from reset release.

Source files
------------

// File: rtl/input_conditioner.sv
// Synchronise and debounce DE0 slide switches and push-buttons.
// Buttons are inverted on entry so all downstream logic is active-high.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] sw_raw,
  input  logic [2:0] button_raw,
  output logic [7:0] sw_stable,
  output logic       sw_changed,
  output logic [2:0] button_level,
  output logic [2:0] button_press,
  output logic [2:0] button_release
);

  localparam int N = 11;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    PENDING
  } state_e;

  state_e           state_q [N];
  state_e           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];

  logic [N-1:0] s1_q, s2_q;
  logic [N-1:0] lvl_q, lvl_d, upd;
  logic [2:0]   press_q, press_d;
  logic [2:0]   rel_q, rel_d;
  logic         chg_q, chg_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q    <= {~button_raw, sw_raw};
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      chg_q   <= chg_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Counter is 0 in STABLE, so hitting LAST there means DEBOUNCE_CYCLES==1.
  always_comb begin
    lvl_d = lvl_q;
    upd   = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        STABLE: begin
          if (s2_q[i] != lvl_q[i]) begin
            if (cnt_q[i] == LAST) begin
              upd[i] = 1'b1;
            end else begin
              state_d[i] = PENDING;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (s2_q[i] == lvl_q[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LAST) begin
            upd[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
      if (upd[i]) begin
        lvl_d[i]   = s2_q[i];
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end
    end
    chg_d   = |upd[7:0];
    press_d = upd[10:8] & s2_q[10:8];
    rel_d   = upd[10:8] & ~s2_q[10:8];
  end

  assign sw_stable      = lvl_q[7:0];
  assign sw_changed     = chg_q;
  assign button_level   = lvl_q[10:8];
  assign button_press   = press_q;
  assign button_release = rel_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Expected output bundles are queued with their due edge.
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] sw_raw;
  logic [2:0] button_raw;
  logic [7:0] sw_stable;
  logic       sw_changed;
  logic [2:0] button_level;
  logic [2:0] button_press;
  logic [2:0] button_release;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .button_raw(button_raw),
    .sw_stable(sw_stable),
    .sw_changed(sw_changed),
    .button_level(button_level),
    .button_press(button_press),
    .button_release(button_release)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [17:0] v;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ecnt = 0;
  logic [17:0] steady = '0;
  string       phase = "reset";

  function automatic logic [17:0] outs();
    return {sw_stable, sw_changed, button_level,
            button_press, button_release};
  endfunction

  function automatic logic [17:0] mk(
    input logic [7:0] sw, input logic chg,
    input logic [2:0] lvl, input logic [2:0] pr,
    input logic [2:0] rl);
    return {sw, chg, lvl, pr, rl};
  endfunction

  task automatic cmp(input string tag, input logic [17:0] exp);
    checks++;
    assert (outs() === exp) else begin
      errors++;
      $error("FAIL %s/%s edge %0d got %h exp %h",
             phase, tag, ecnt, outs(), exp);
    end
  endtask

  task automatic expect_at(input int dly, input logic [17:0] v);
    exp_t e;
    e.due = ecnt + dly;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clock);
      #1;
      ecnt++;
      if (q.size() != 0 && q[0].due == ecnt) begin
        e = q.pop_front();
        cmp("update", e.v);
        steady = {e.v[17:10], 1'b0, e.v[8:6], 6'b0};
      end else begin
        cmp("steady", steady);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    sw_raw     = 8'h00;
    button_raw = 3'b111;
    tick(3);
    #4 reset_n = 1'b1;
    tick(8);

    phase = "sw_ff";
    sw_raw = 8'hFF;
    expect_at(6, mk(8'hFF, 1'b1, 3'b000, 3'b000, 3'b000));
    tick(8);

    phase = "async_reset";
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    steady = '0;
    cmp("immediate", '0);
    tick(2);
    #4 reset_n = 1'b1;
    expect_at(6, mk(8'hFF, 1'b1, 3'b000, 3'b000, 3'b000));
    tick(8);

    phase = "clean_press";
    button_raw = 3'b011;
    expect_at(6, mk(8'hFF, 1'b0, 3'b100, 3'b100, 3'b000));
    tick(8);

    phase = "sw_clear";
    sw_raw = 8'h00;
    expect_at(6, mk(8'h00, 1'b1, 3'b100, 3'b000, 3'b000));
    tick(8);

    phase = "bounce_short";
    sw_raw = 8'h01;
    tick(3);
    sw_raw = 8'h00;
    tick(8);

    phase = "bounce_glitch";
    sw_raw = 8'h01;
    tick(2);
    sw_raw = 8'h00;
    tick(1);
    sw_raw = 8'h01;
    expect_at(6, mk(8'h01, 1'b1, 3'b100, 3'b000, 3'b000));
    tick(8);

    phase = "sw_zero";
    sw_raw = 8'h00;
    expect_at(6, mk(8'h00, 1'b1, 3'b100, 3'b000, 3'b000));
    tick(8);

    phase = "simultaneous";
    sw_raw = 8'hA5;
    expect_at(6, mk(8'hA5, 1'b1, 3'b100, 3'b000, 3'b000));
    tick(8);

    phase = "press_b0";
    button_raw = 3'b010;
    expect_at(6, mk(8'hA5, 1'b0, 3'b101, 3'b001, 3'b000));
    tick(8);

    phase = "press_release_mix";
    button_raw = 3'b001;
    expect_at(6, mk(8'hA5, 1'b0, 3'b110, 3'b010, 3'b001));
    tick(8);

    phase = "reset_mid_debounce";
    sw_raw = 8'hAD;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    steady = '0;
    cmp("immediate", '0);
    tick(1);
    #4 reset_n = 1'b1;
    expect_at(6, mk(8'hAD, 1'b1, 3'b110, 3'b110, 3'b000));
    tick(8);

    phase = "drain";
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain pending %0d exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
